// File: rtl/shooter_pkg.sv
// Shared bullet FSM state and screen geometry for the shooter game engine.
// Coordinates are in the renderer's hCount/vCount space.
package shooter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLIGHT,
    HIT
  } bullet_state_t;

  localparam int SHIP_W     = 40;
  localparam int SHIP_TOP   = 400;
  localparam int BULLET_W   = 10;
  localparam int BULLET_H   = 20;
  localparam int LAUNCH_Y   = 380;
  localparam int LAUNCH_OFS = 15;
  localparam int ENEMY_X0   = 320;
  localparam int ENEMY_X1   = 340;
  localparam int ENEMY_Y0   = 84;
  localparam int ENEMY_Y1   = 124;

  // Add one to a 4-digit BCD value; 9999 wraps to 0000.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Four-digit BCD score register for the seven-segment driver.
// One increment per inc pulse, wrapping 9999 -> 0000.
module bcd_score_counter
  import shooter_pkg::*;
(
  input  logic        clk,
  input  logic        Reset,
  input  logic        inc,
  output logic [15:0] score
);

  // Score register, advanced by one BCD count per inc cycle
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      score <= 16'h0000;
    end else if (inc) begin
      score <= bcd_inc(score);
    end
  end

endmodule

// File: rtl/shooter_game_core.sv
// Game-state engine: ship position, single bullet, enemy hit, BCD score.
// All game state advances only on the one-cycle game tick.
module shooter_game_core
  import shooter_pkg::*;
#(
  parameter int TICK_CYCLES  = 500000,
  parameter int PLAYER_STEP  = 2,
  parameter int BULLET_STEP  = 4,
  parameter int X_MIN        = 144,
  parameter int X_MAX        = 744,
  parameter int PLAYER_X_RST = 424,
  parameter int BULLET_TOP   = 39,
  parameter int HIT_HOLD     = 32
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        BtnL,
  input  logic        BtnR,
  input  logic        BtnC,
  output logic [9:0]  x_position_player,
  output logic [9:0]  ben_x,
  output logic [9:0]  ben_v,
  output logic        collision,
  output logic [15:0] score
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int HW = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;

  logic [1:0]    l_sync;
  logic [1:0]    r_sync;
  logic [2:0]    c_sync;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          fire_edge;
  logic          fire_pending;
  logic          btn_l;
  logic          btn_r;
  logic [10:0]   x_up;
  logic [10:0]   x_dn;
  logic [9:0]    x_right;
  logic [9:0]    x_left;
  logic [10:0]   bx;
  logic [10:0]   bv;
  logic          overlap;
  logic          hit_inc;
  logic [HW-1:0] hold_cnt;
  bullet_state_t state;

  assign btn_l     = l_sync[1];
  assign btn_r     = r_sync[1];
  assign fire_edge = c_sync[1] & ~c_sync[2];
  assign tick      = (tick_cnt == CW'(TICK_CYCLES - 1));

  // Bring the asynchronous buttons into the clk domain
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      l_sync <= '0;
      r_sync <= '0;
      c_sync <= '0;
    end else begin
      l_sync <= {l_sync[0], BtnL};
      r_sync <= {r_sync[0], BtnR};
      c_sync <= {c_sync[1:0], BtnC};
    end
  end

  // Free-running game tick divider
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  // Clamped step targets, 11 bits wide so nothing wraps
  always_comb begin
    x_up    = {1'b0, x_position_player} + 11'(PLAYER_STEP);
    x_dn    = {1'b0, x_position_player} - 11'(PLAYER_STEP);
    x_right = (x_up > 11'(X_MAX)) ? 10'(X_MAX) : x_up[9:0];
    x_left  = ({1'b0, x_position_player} < 11'(X_MIN + PLAYER_STEP))
            ? 10'(X_MIN) : x_dn[9:0];
  end

  // Ship moves on tick when exactly one direction is held
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      x_position_player <= 10'(PLAYER_X_RST);
    end else if (tick) begin
      unique case (1'b1)
        btn_r & ~btn_l: x_position_player <= x_right;
        btn_l & ~btn_r: x_position_player <= x_left;
        default:        x_position_player <= x_position_player;
      endcase
    end
  end

  // A press is only kept while the bullet is parked; consumed by a tick
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      fire_pending <= 1'b0;
    end else if (state != IDLE) begin
      fire_pending <= 1'b0;
    end else if (fire_edge) begin
      fire_pending <= 1'b1;
    end else if (tick) begin
      fire_pending <= 1'b0;
    end
  end

  // Bullet against the enemy box, on the current coordinates
  always_comb begin
    bx      = {1'b0, ben_x};
    bv      = {1'b0, ben_v};
    overlap = (bx < 11'(ENEMY_X1))
            && (bx + 11'(BULLET_W) > 11'(ENEMY_X0))
            && (bv <= 11'(ENEMY_Y1))
            && (bv + 11'(BULLET_H) >= 11'(ENEMY_Y0));
    hit_inc = tick && (state == FLIGHT) && overlap;
  end

  // Bullet FSM with registered coordinates and hit flag
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      ben_x     <= '0;
      ben_v     <= '0;
      collision <= 1'b0;
      hold_cnt  <= '0;
    end else if (tick) begin
      unique case (state)
        IDLE: begin
          ben_x <= '0;
          ben_v <= '0;
          if (fire_pending) begin
            ben_x <= x_position_player + 10'(LAUNCH_OFS);
            ben_v <= 10'(LAUNCH_Y);
            state <= FLIGHT;
          end
        end
        FLIGHT: begin
          if (overlap) begin
            state     <= HIT;
            collision <= 1'b1;
            ben_x     <= '0;
            ben_v     <= '0;
            hold_cnt  <= '0;
          end else if (ben_v < 10'(BULLET_TOP)) begin
            state <= IDLE;
            ben_x <= '0;
            ben_v <= '0;
          end else begin
            ben_v <= ben_v - 10'(BULLET_STEP);
          end
        end
        HIT: begin
          if (hold_cnt == HW'(HIT_HOLD - 1)) begin
            collision <= 1'b0;
            state     <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  bcd_score_counter u_score (
    .clk   (clk),
    .Reset (Reset),
    .inc   (hit_inc),
    .score (score)
  );

endmodule

// File: tb/tb_shooter_game_core.sv
// Directed bench for shooter_game_core (TICK_CYCLES=4) and the
// standalone BCD score counter.
module tb_shooter_game_core;

  logic        clk = 1'b0;
  logic        Reset;
  logic        BtnL;
  logic        BtnR;
  logic        BtnC;
  logic [9:0]  x_position_player;
  logic [9:0]  ben_x;
  logic [9:0]  ben_v;
  logic        collision;
  logic [15:0] score;

  logic        b_rst;
  logic        b_inc;
  logic [15:0] b_score;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shooter_game_core #(.TICK_CYCLES(4)) dut (
    .clk               (clk),
    .Reset             (Reset),
    .BtnL              (BtnL),
    .BtnR              (BtnR),
    .BtnC              (BtnC),
    .x_position_player (x_position_player),
    .ben_x             (ben_x),
    .ben_v             (ben_v),
    .collision         (collision),
    .score             (score)
  );

  bcd_score_counter u_bcd (
    .clk   (clk),
    .Reset (b_rst),
    .inc   (b_inc),
    .score (b_score)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance n game ticks; entered and left 1 ns after a tick edge
  task automatic tk(input int n);
    repeat (n * 4) @(posedge clk);
    #1;
  endtask

  task automatic hit_run(input int k);
    BtnC = 1'b1;
    tk(1);
    chk($sformatf("launch_x%0d", k), 16'(ben_x), 16'd319);
    BtnC = 1'b0;
    tk(64);
    chk($sformatf("pre_hit_v%0d", k), 16'(ben_v), 16'd124);
    tk(1);
    chk($sformatf("coll%0d", k), 16'(collision), 16'd1);
    tk(32);
    chk($sformatf("coll_end%0d", k), 16'(collision), 16'd0);
  endtask

  initial begin
    Reset = 1'b1;
    BtnL  = 1'b0;
    BtnR  = 1'b0;
    BtnC  = 1'b0;
    b_rst = 1'b1;
    b_inc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", 16'(x_position_player), 16'd424);
    chk("rst_bx", 16'(ben_x), 16'd0);
    chk("rst_bv", 16'(ben_v), 16'd0);
    chk("rst_col", 16'(collision), 16'd0);
    chk("rst_score", score, 16'h0000);

    // Standalone BCD counter
    b_rst = 1'b0;
    b_inc = 1'b1;
    repeat (99) @(posedge clk);
    #1;
    chk("bcd_0099", b_score, 16'h0099);
    @(posedge clk);
    #1;
    chk("bcd_0100", b_score, 16'h0100);
    repeat (9899) @(posedge clk);
    #1;
    chk("bcd_9999", b_score, 16'h9999);
    @(posedge clk);
    #1;
    chk("bcd_wrap", b_score, 16'h0000);
    b_inc = 1'b0;

    // Release game reset aligned so ticks fall every 4th edge after it
    @(posedge clk);
    #1;
    Reset = 1'b0;

    // Player movement
    BtnR = 1'b1;
    tk(1);
    chk("r_step", 16'(x_position_player), 16'd426);
    tk(199);
    chk("r_sat", 16'(x_position_player), 16'd744);
    BtnL = 1'b1;
    tk(10);
    chk("lr_hold", 16'(x_position_player), 16'd744);
    BtnR = 1'b0;
    tk(1);
    chk("l_step", 16'(x_position_player), 16'd742);
    tk(399);
    chk("l_sat", 16'(x_position_player), 16'd144);
    BtnL = 1'b0;
    BtnR = 1'b1;
    tk(140);
    BtnR = 1'b0;
    chk("x_424", 16'(x_position_player), 16'd424);

    // Miss path with a second press during flight
    BtnC = 1'b1;
    tk(1);
    chk("miss_bx", 16'(ben_x), 16'd439);
    chk("miss_bv", 16'(ben_v), 16'd380);
    BtnC = 1'b0;
    tk(1);
    chk("miss_v376", 16'(ben_v), 16'd376);
    BtnC = 1'b1;
    tk(1);
    BtnC = 1'b0;
    chk("no_relaunch", 16'(ben_v), 16'd372);
    chk("no_relaunch_x", 16'(ben_x), 16'd439);
    tk(84);
    chk("miss_v36", 16'(ben_v), 16'd36);
    tk(1);
    chk("miss_park_x", 16'(ben_x), 16'd0);
    chk("miss_park_v", 16'(ben_v), 16'd0);
    chk("miss_col", 16'(collision), 16'd0);
    chk("miss_score", score, 16'h0000);
    tk(2);
    chk("miss_idle", 16'(ben_v), 16'd0);

    // Hit path
    BtnL = 1'b1;
    tk(60);
    BtnL = 1'b0;
    chk("x_304", 16'(x_position_player), 16'd304);
    BtnC = 1'b1;
    tk(1);
    chk("hit_bx", 16'(ben_x), 16'd319);
    chk("hit_bv", 16'(ben_v), 16'd380);
    BtnC = 1'b0;
    tk(64);
    chk("hit_v124", 16'(ben_v), 16'd124);
    chk("hit_pre_col", 16'(collision), 16'd0);
    tk(1);
    chk("hit_col", 16'(collision), 16'd1);
    chk("hit_score", score, 16'h0001);
    chk("hit_park_x", 16'(ben_x), 16'd0);
    chk("hit_park_v", 16'(ben_v), 16'd0);
    tk(31);
    chk("hold_31", 16'(collision), 16'd1);
    tk(1);
    chk("hold_end", 16'(collision), 16'd0);

    for (int k = 2; k <= 10; k++) hit_run(k);
    chk("score_10", score, 16'h0010);

    // Reset in the middle of a flight
    BtnR = 1'b1;
    BtnC = 1'b1;
    tk(1);
    BtnC = 1'b0;
    tk(10);
    chk("mid_x", 16'(x_position_player), 16'd326);
    Reset = 1'b1;
    #1;
    chk("mrst_x", 16'(x_position_player), 16'd424);
    chk("mrst_bx", 16'(ben_x), 16'd0);
    chk("mrst_bv", 16'(ben_v), 16'd0);
    chk("mrst_col", 16'(collision), 16'd0);
    chk("mrst_score", score, 16'h0000);
    BtnR = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
